// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam logic [BE_W-1:0] BE_FULL = 4'hF;

    // Bit positions inside the one-hot requester select
    localparam int SEL_IF = 0;
    localparam int SEL_LS = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2
    } arb_state_t;

    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals of the arbiter.
// master: the arbiter itself; slave: the requesters and memory around it.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Requester selection: load/store wins unless it has used up its streak
// while a fetch is waiting, in which case the fetch wins.
module arb_prio_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_LS_STREAK = 4,
    parameter int STREAK_W      = 3
) (
    input  logic                if_req,
    input  logic                ls_req,
    input  logic [STREAK_W-1:0] ls_streak,
    output logic [1:0]          sel
);

    logic streak_full;

    assign streak_full = (ls_streak == STREAK_W'(MAX_LS_STREAK));

    always_comb begin
        sel = '0;
        if (ls_req && !(if_req && streak_full)) begin
            sel[SEL_LS] = 1'b1;
        end else if (if_req) begin
            sel[SEL_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter (fetch vs load/store), one access in flight.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_LS_STREAK = 4,
    parameter int TIMEOUT_CYC   = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_port_arbiter_if.master        bus,
    output logic                      busy,
    output logic                      err
);

    localparam int STREAK_W = streak_width(MAX_LS_STREAK);

    if (MAX_LS_STREAK < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: MAX_LS_STREAK and TIMEOUT_CYC must be at least 1");
    end

    arb_state_t          state;
    logic [STREAK_W-1:0] ls_streak;
    logic [1:0]          sel;
    logic                if_gnt;
    logic                ls_gnt;

    logic                cap_we;
    logic [BE_W-1:0]     cap_be;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;

    logic                if_rvalid;
    logic                ls_rvalid;
    logic [DATA_W-1:0]   if_rdata;
    logic [DATA_W-1:0]   ls_rdata;

    arb_prio_sel #(
        .MAX_LS_STREAK (MAX_LS_STREAK),
        .STREAK_W      (STREAK_W)
    ) u_prio_sel (
        .if_req    (bus.if_req),
        .ls_req    (bus.ls_req),
        .ls_streak (ls_streak),
        .sel       (sel)
    );

    // Grants are offered only while idle and out of reset, so nothing is captured early
    assign if_gnt = (state == IDLE) && !rst && sel[SEL_IF];
    assign ls_gnt = (state == IDLE) && !rst && sel[SEL_LS];

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    logic            timed_out;

    assign timed_out = (state != IDLE) && !bus.mem_ack && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timed_out;
            if (state == IDLE || bus.mem_ack) begin
                to_cnt <= '0;
            end else if (!timed_out) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
`else
    logic timed_out;

    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ls_streak <= '0;
            cap_we    <= 1'b0;
            cap_be    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_gnt) begin
                        state     <= IF_ACC;
                        cap_we    <= 1'b0;
                        cap_be    <= BE_FULL;
                        cap_addr  <= bus.if_addr;
                        cap_wdata <= '0;
                        ls_streak <= '0;
                    end else if (ls_gnt) begin
                        state     <= LS_ACC;
                        cap_we    <= bus.ls_we;
                        cap_be    <= bus.ls_be;
                        cap_addr  <= bus.ls_addr;
                        cap_wdata <= bus.ls_wdata;
                        // Streak counts only the grants that made a fetch wait
                        if (!bus.if_req) begin
                            ls_streak <= '0;
                        end else if (ls_streak != STREAK_W'(MAX_LS_STREAK)) begin
                            ls_streak <= ls_streak + STREAK_W'(1);
                        end
                    end
                end
                IF_ACC: begin
                    if (bus.mem_ack) begin
                        state     <= IDLE;
                        if_rdata  <= bus.mem_rdata;
                        if_rvalid <= 1'b1;
                    end else if (timed_out) begin
                        state     <= IDLE;
                        if_rdata  <= '0;
                        if_rvalid <= 1'b1;
                    end
                end
                LS_ACC: begin
                    if (bus.mem_ack) begin
                        state     <= IDLE;
                        ls_rdata  <= bus.mem_rdata;
                        ls_rvalid <= 1'b1;
                    end else if (timed_out) begin
                        state     <= IDLE;
                        ls_rdata  <= '0;
                        ls_rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.ls_rvalid = ls_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.ls_rdata  = ls_rdata;

    assign bus.mem_en    = (state != IDLE);
    assign bus.mem_we    = cap_we;
    assign bus.mem_be    = cap_be;
    assign bus.mem_addr  = cap_addr;
    assign bus.mem_wdata = cap_wdata;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter; the watchdog case runs when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err;

    int n_checks = 0;
    int n_err    = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_LS_STREAK (4),
        .TIMEOUT_CYC   (15)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "bench time limit");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic if_req;
        logic ls_req;
        logic exp_if_gnt;
        logic exp_ls_gnt;
    } gnt_vec_t;

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_we;
        logic [3:0]  exp_be;
    } txn_t;

    // One complete access: grant in cycle 0, lat cycles in the ACC state with ack in the last, rvalid next
    task automatic run_txn(input txn_t t);
        @(negedge clk);
        if (t.is_ls) begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = t.we;
            bus.ls_be    = t.be;
            bus.ls_addr  = t.addr;
            bus.ls_wdata = t.wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = t.addr;
        end
        #1;
        check1("txn_if_gnt", bus.if_gnt, !t.is_ls);
        check1("txn_ls_gnt", bus.ls_gnt, t.is_ls);
        for (int k = 1; k <= t.lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.if_req = 1'b0;
                bus.ls_req = 1'b0;
            end
            check1("txn_mem_en", bus.mem_en, 1'b1);
            check1("txn_busy", busy, 1'b1);
            check32("txn_mem_addr", bus.mem_addr, t.addr);
            check1("txn_mem_we", bus.mem_we, t.exp_we);
            check32("txn_mem_be", 32'(bus.mem_be), 32'(t.exp_be));
            if (t.is_ls) check32("txn_mem_wdata", bus.mem_wdata, t.wdata);
            if (k == t.lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = t.rdata;
            end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check1("txn_if_rvalid", bus.if_rvalid, !t.is_ls);
        check1("txn_ls_rvalid", bus.ls_rvalid, t.is_ls);
        check32("txn_rdata", t.is_ls ? bus.ls_rdata : bus.if_rdata, t.rdata);
        check1("txn_busy_done", busy, 1'b0);
        check1("txn_err", err, 1'b0);
        @(negedge clk);
        check1("txn_rvalid_pulse", bus.if_rvalid | bus.ls_rvalid, 1'b0);
    endtask

    gnt_vec_t gvec[4];
    txn_t     tvec[4];
    logic     exp_order[6];
    logic     got_order[6];
    int       n_gnt;

    initial begin
        gvec[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        gvec[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        gvec[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        gvec[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        tvec[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_5678, 2, 1'b0, 4'hF};
        tvec[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0200, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 1, 1'b1, 4'h3};
        tvec[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h1111_2222, 32'hCAFE_F00D, 1, 1'b0, 4'hF};
        tvec[3] = '{1'b0, 1'b1, 4'h1, 32'h0000_0080, 32'h0, 32'h0BAD_C0DE, 3, 1'b0, 4'hF};

        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst           = 1'b1;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0990;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_be     = 4'h0;
        bus.ls_addr   = 32'h0;
        bus.ls_wdata  = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;

        // Reset state, and no grant while reset is held even with a request pending
        repeat (2) @(negedge clk);
        check1("rst_if_gnt", bus.if_gnt, 1'b0);
        check1("rst_mem_en", bus.mem_en, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_rvalid", bus.if_rvalid | bus.ls_rvalid, 1'b0);
        check32("rst_if_rdata", bus.if_rdata, 32'h0);
        check32("rst_ls_rdata", bus.ls_rdata, 32'h0);
        check32("rst_mem_addr", bus.mem_addr, 32'h0);
        bus.if_req = 1'b0;
        rst        = 1'b0;

        // Combinational grant selection while idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.if_req = gvec[i].if_req;
            bus.ls_req = gvec[i].ls_req;
            #1;
            check1("comb_if_gnt", bus.if_gnt, gvec[i].exp_if_gnt);
            check1("comb_ls_gnt", bus.ls_gnt, gvec[i].exp_ls_gnt);
            bus.if_req = 1'b0;
            bus.ls_req = 1'b0;
        end

        // Stray ack while idle must not produce a completion
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check1("stray_rvalid", bus.if_rvalid | bus.ls_rvalid, 1'b0);
        check1("stray_busy", busy, 1'b0);
        @(negedge clk);
        check1("stray_rvalid_late", bus.if_rvalid | bus.ls_rvalid, 1'b0);
        check32("stray_if_rdata", bus.if_rdata, 32'h0);

        for (int i = 0; i < 4; i++) run_txn(tvec[i]);
        check32("hold_ls_rdata", bus.ls_rdata, 32'hCAFE_F00D);

        // Simultaneous requests: store first, then the waiting fetch in the rvalid cycle
        @(negedge clk);
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0300;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_be    = 4'h3;
        bus.ls_addr  = 32'h0000_0200;
        bus.ls_wdata = 32'hDEAD_BEEF;
        #1;
        check1("both_ls_gnt", bus.ls_gnt, 1'b1);
        check1("both_if_gnt", bus.if_gnt, 1'b0);
        @(negedge clk);
        bus.ls_req = 1'b0;
        check1("both_mem_we", bus.mem_we, 1'b1);
        check32("both_mem_be", 32'(bus.mem_be), 32'h3);
        check32("both_mem_addr", bus.mem_addr, 32'h0000_0200);
        check1("both_no_gnt_in_acc", bus.if_gnt, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check1("both_ls_rvalid", bus.ls_rvalid, 1'b1);
        check1("both_if_gnt_late", bus.if_gnt, 1'b1);
        @(negedge clk);
        bus.if_req = 1'b0;
        check32("both_fetch_addr", bus.mem_addr, 32'h0000_0300);
        check1("both_fetch_we", bus.mem_we, 1'b0);
        check32("both_fetch_be", 32'(bus.mem_be), 32'hF);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_0001;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check1("both_if_rvalid", bus.if_rvalid, 1'b1);
        check32("both_if_rdata", bus.if_rdata, 32'h7777_0001);

        // Continuous contention: LSU streak then a forced fetch
        @(negedge clk);
        bus.ls_we  = 1'b0;
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        n_gnt      = 0;
        for (int cyc = 0; cyc < 40 && n_gnt < 6; cyc++) begin
            #1;
            bus.mem_ack = bus.mem_en;
            if (bus.ls_gnt) begin
                got_order[n_gnt] = 1'b1;
                n_gnt++;
            end else if (bus.if_gnt) begin
                got_order[n_gnt] = 1'b0;
                n_gnt++;
            end
            if (n_gnt < 6) @(negedge clk);
        end
        check32("streak_grant_count", 32'(n_gnt), 32'd6);
        for (int i = 0; i < 6 && i < n_gnt; i++) check1("streak_order_is_ls", got_order[i], exp_order[i]);
        @(negedge clk);
        bus.if_req  = 1'b0;
        bus.ls_req  = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check1("streak_last_ls_rvalid", bus.ls_rvalid, 1'b1);

        // Asynchronous reset in the middle of a load/store access
        @(negedge clk);
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h0000_0ABC;
        @(negedge clk);
        bus.ls_req = 1'b0;
        check1("arst_pre_mem_en", bus.mem_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("arst_mem_en", bus.mem_en, 1'b0);
        check1("arst_busy", busy, 1'b0);
        check1("arst_rvalid", bus.ls_rvalid, 1'b0);
        check32("arst_ls_rdata", bus.ls_rdata, 32'h0);
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("arst_no_ls_rvalid", bus.ls_rvalid, 1'b0);
            check1("arst_idle", busy, 1'b0);
            @(negedge clk);
        end

`ifdef ARB_TIMEOUT_EN
        // Fetch that is never acknowledged
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0F00;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.if_req = 1'b0;
            check1("to_waiting", bus.mem_en, 1'b1);
            check1("to_no_err_yet", err, 1'b0);
        end
        @(negedge clk);
        check1("to_if_rvalid", bus.if_rvalid, 1'b1);
        check32("to_if_rdata", bus.if_rdata, 32'h0);
        check1("to_err", err, 1'b1);
        check1("to_idle", busy, 1'b0);
        @(negedge clk);
        check1("to_err_pulse", err, 1'b0);
        check1("to_rvalid_pulse", bus.if_rvalid, 1'b0);
`else
        check1("no_timeout_err", err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
